// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings and helpers for the data-memory arbiter
// Purpose: access-size encodings, FSM state encoding, round-robin port identifiers
//          and the sub-word load extension helper.
// Ports:   none (package)
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ARB    = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Extend a right-aligned byte (half=0) or half-word (half=1) to 32 bits.
  function automatic logic [DATA_W-1:0] ext_load(input logic [15:0] v,
                                                 input logic        half,
                                                 input logic        uns);
    logic [DATA_W-1:0] r;
    if (half) r = {{16{~uns & v[15]}}, v};
    else      r = {{24{~uns & v[7]}}, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between core ports, arbiter and data memory
// Purpose: groups the fetch port (i_*), load/store port (d_*) and memory port (m_*).
// Ports:   slave  - arbiter view (requests in, acks/data out, drives memory)
//          master - environment view (core requesters plus the memory array)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 6
);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [31:0]       d_rdata;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_ack, d_err, d_rdata,
    output m_read, m_write, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_ack, d_err, d_rdata,
    input  m_read, m_write, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter_byte_lane_unit.sv
// rtl/dmem_arbiter_byte_lane_unit.sv - sub-word load extraction, store merge and misalign detect
// Purpose: purely combinational lane logic for the D port.
// Ports:   size/uns/lane - access size, zero-extend flag, byte address bits [1:0]
//          rdata/wdata   - current memory word, right-aligned store data
//          load_data     - extracted and extended load result
//          merged        - rdata with the addressed lane(s) replaced by store data
//          err           - misaligned half/word or reserved size
module byte_lane_unit
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged,
  output logic              err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        unused_wdata;

  assign unused_wdata = &{1'b0, wdata[31:16]};

  always_comb begin
    sel_byte  = rdata[8*lane +: 8];
    sel_half  = rdata[16*lane[1] +: 16];
    err       = 1'b0;
    load_data = rdata;
    merged    = rdata;
    case (size)
      SIZE_B: begin
        load_data              = ext_load({8'h00, sel_byte}, 1'b0, uns);
        merged[8*lane +: 8]    = wdata[7:0];
      end
      SIZE_H: begin
        err                    = lane[0];
        load_data              = ext_load(sel_half, 1'b1, uns);
        merged[16*lane[1] +: 16] = wdata[15:0];
      end
      SIZE_W: begin
        err                    = (lane != 2'b00);
      end
      default: begin
        err                    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory between fetch and load/store
// Purpose: grants the I (fetch) or D (load/store) port one memory access per cycle,
//          returns registered acks, and performs byte/half stores as read-modify-write.
// Ports:   clk - system clock
//          rst - asynchronous active-high reset
//          bus - dmem_arbiter_if.slave (i_*, d_*, m_* signal groups)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  dmem_arbiter_if.slave bus
);

  state_e            state;
  port_e             last_gnt;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_word;

  logic              i_ack_q, d_ack_q, d_err_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              i_elig, d_elig, gnt_i, gnt_d;
  logic              d_word_store, d_sub_store;
  logic [DATA_W-1:0] lane_load, lane_merged;
  logic              lane_err;

  logic              m_read_c, m_write_c;
  logic [ADDR_W-1:0] m_addr_c;
  logic [DATA_W-1:0] m_wdata_c;

  logic [ADDR_W-1:0] i_word, d_word;
  logic              unused_addr;

  assign i_word      = bus.i_addr[ADDR_W+1:2];
  assign d_word      = bus.d_addr[ADDR_W+1:2];
  assign unused_addr = &{1'b0, bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                         bus.d_addr[31:ADDR_W+2]};

  byte_lane_unit u_lane (
    .size      (bus.d_size),
    .uns       (bus.d_unsigned),
    .lane      (bus.d_addr[1:0]),
    .rdata     (bus.m_rdata),
    .wdata     (bus.d_wdata),
    .load_data (lane_load),
    .merged    (lane_merged),
    .err       (lane_err)
  );

  assign d_word_store = bus.d_we & (bus.d_size == SIZE_W);
  assign d_sub_store  = bus.d_we & (bus.d_size != SIZE_W);

  // A port is not eligible in its own ack cycle, so a held request is never served twice.
  always_comb begin
    i_elig = bus.i_req & ~i_ack_q;
    d_elig = bus.d_req & ~d_ack_q;
    gnt_d  = 1'b0;
    gnt_i  = 1'b0;
    if (state == ARB) begin
      gnt_d = d_elig & (~i_elig | (last_gnt == PORT_I));
      gnt_i = i_elig & ~gnt_d;
    end
  end

  // Memory port: the RMW write phase owns the memory; otherwise the granted request drives it.
  always_comb begin
    m_read_c  = 1'b0;
    m_write_c = 1'b0;
    m_addr_c  = '0;
    m_wdata_c = '0;
    if (state == RMW_WR) begin
      m_write_c = 1'b1;
      m_addr_c  = rmw_addr;
      m_wdata_c = rmw_word;
    end else if (gnt_i) begin
      m_read_c  = 1'b1;
      m_addr_c  = i_word;
    end else if (gnt_d && !lane_err) begin
      m_addr_c  = d_word;
      if (d_word_store) begin
        m_write_c = 1'b1;
        m_wdata_c = bus.d_wdata;
      end else begin
        m_read_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      last_gnt  <= PORT_I;
      rmw_addr  <= '0;
      rmw_word  <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state)
        ARB: begin
          if (gnt_i) begin
            last_gnt  <= PORT_I;
            i_ack_q   <= 1'b1;
            i_rdata_q <= bus.m_rdata;
          end else if (gnt_d) begin
            last_gnt <= PORT_D;
            if (lane_err) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
            end else if (!bus.d_we) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= lane_load;
            end else if (!d_sub_store) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              // Read phase of RMW: capture the merged word, write it next cycle.
              rmw_addr <= d_word;
              rmw_word <= lane_merged;
              state    <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= '0;
          state     <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_read  = m_read_c;
  assign bus.m_write = m_write_c;
  assign bus.m_addr  = m_addr_c;
  assign bus.m_wdata = m_wdata_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [31:0] mem [64];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  dmem_arbiter_if #(.ADDR_W(6)) bus ();

  dmem_arbiter #(.ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.m_rdata = mem[bus.m_addr];

  always @(posedge clk) begin
    if (bus.m_write)  mem[bus.m_addr] <= bus.m_wdata;
    else if (bd_we)   mem[bd_addr]    <= bd_data;
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] v);
    bd_addr = a;
    bd_data = v;
    bd_we   = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_size     = 2'b10;
    bus.d_unsigned = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one D transaction, wait (bounded) for d_ack, return latency/data/error.
  task automatic d_xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output logic saw_write);
    lat       = 99;
    rdata     = 32'hDEAD_BEEF;
    err       = 1'bx;
    saw_write = 1'b0;
    bus.d_we       = we;
    bus.d_size     = size;
    bus.d_unsigned = uns;
    bus.d_addr     = addr;
    bus.d_wdata    = wdata;
    bus.d_req      = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      saw_write |= bus.m_write;
      if (bus.d_ack) begin
        lat   = n;
        rdata = bus.d_rdata;
        err   = bus.d_err;
        break;
      end
    end
    @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_total++;
    if ({bus.i_ack, bus.d_ack, bus.d_err, bus.m_read, bus.m_write} !== 5'b0 ||
        bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
      $display("FAIL reset_outputs: acks/err/rd/wr=%b i_rdata=%h d_rdata=%h, want all 0",
               {bus.i_ack, bus.d_ack, bus.d_err, bus.m_read, bus.m_write},
               bus.i_rdata, bus.d_rdata);
    else n_pass++;
  endtask

  task automatic test_fetch();
    do_reset();
    preload(6'd1, 32'd9);
    bus.i_addr = 32'h4;
    bus.i_req  = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.m_read !== 1'b1 || bus.m_addr !== 6'd1)
      $display("FAIL fetch_grant: m_read=%b m_addr=%0d, want 1/1", bus.m_read, bus.m_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'd9)
      $display("FAIL fetch_ack: i_ack=%b i_rdata=%h, want 1/00000009", bus.i_ack, bus.i_rdata);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] who;
    logic [7:0] want;
    do_reset();
    bus.i_addr     = 32'h10;
    bus.d_addr     = 32'h20;
    bus.d_we       = 1'b0;
    bus.d_size     = 2'b10;
    bus.i_req      = 1'b1;
    bus.d_req      = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      want = (k % 2 == 0) ? "D" : "I";
      if (bus.m_read && bus.m_addr == 6'd8)      who = "D";
      else if (bus.m_read && bus.m_addr == 6'd4) who = "I";
      else                                       who = "N";
      n_total++;
      if (who !== want)
        $display("FAIL rr_grant%0d: granted %c, want %c", k, who, want);
      else n_pass++;
    end
    @(posedge clk);
    #1 begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
    @(negedge clk);
    n_total++;
    if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0 || bus.m_addr !== 6'd0 || bus.m_wdata !== 32'h0)
      $display("FAIL idle_mem: rd=%b wr=%b addr=%0d wdata=%h, want 0/0/0/0",
               bus.m_read, bus.m_write, bus.m_addr, bus.m_wdata);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_loads();
    int          lat;
    logic [31:0] rd;
    logic        err, sw;
    do_reset();
    preload(6'd2, 32'h0000_0080);
    d_xfer(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, lat, rd, err, sw);
    n_total++;
    if (rd !== 32'hFFFF_FF80 || lat != 1 || err !== 1'b0)
      $display("FAIL lb: rdata=%h lat=%0d err=%b, want ffffff80/1/0", rd, lat, err);
    else n_pass++;
    d_xfer(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, lat, rd, err, sw);
    n_total++;
    if (rd !== 32'h0000_0080 || lat != 1)
      $display("FAIL lbu: rdata=%h lat=%0d, want 00000080/1", rd, lat);
    else n_pass++;
    d_xfer(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, rd, err, sw);
    n_total++;
    if (rd !== 32'h0000_0000 || lat != 1 || err !== 1'b0)
      $display("FAIL lh_upper: rdata=%h lat=%0d err=%b, want 00000000/1/0", rd, lat, err);
    else n_pass++;
    d_xfer(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, lat, rd, err, sw);
    n_total++;
    if (rd !== 32'h0000_0080)
      $display("FAIL lh_lower: rdata=%h, want 00000080", rd);
    else n_pass++;
  endtask

  task automatic test_sub_store();
    do_reset();
    preload(6'd0, 32'd17);
    preload(6'd1, 32'h0000_0009);
    bus.d_we       = 1'b1;
    bus.d_size     = 2'b00;
    bus.d_unsigned = 1'b0;
    bus.d_addr     = 32'h1;
    bus.d_wdata    = 32'h0000_00AB;
    bus.i_addr     = 32'h4;
    bus.d_req      = 1'b1;
    bus.i_req      = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0 || bus.m_addr !== 6'd0)
      $display("FAIL sb_read_phase: rd=%b wr=%b addr=%0d, want 1/0/0",
               bus.m_read, bus.m_write, bus.m_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0 || bus.m_wdata !== 32'h0000_AB11 ||
        bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0)
      $display("FAIL sb_write_phase: wr=%b rd=%b wdata=%h d_ack=%b i_ack=%b, want 1/0/0000ab11/0/0",
               bus.m_write, bus.m_read, bus.m_wdata, bus.d_ack, bus.i_ack);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h0 || bus.m_read !== 1'b1 || bus.m_addr !== 6'd1)
      $display("FAIL sb_ack_cycle3: d_ack=%b d_rdata=%h i_grant_rd=%b addr=%0d, want 1/0/1/1",
               bus.d_ack, bus.d_rdata, bus.m_read, bus.m_addr);
    else n_pass++;
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h9 || mem[0] !== 32'h0000_AB11)
      $display("FAIL sb_after: i_ack=%b i_rdata=%h mem0=%h, want 1/00000009/0000ab11",
               bus.i_ack, bus.i_rdata, mem[0]);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
  endtask

  task automatic test_errors();
    int          lat;
    logic [31:0] rd;
    logic        err, sw;
    logic [1:0]  sz   [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad   [3] = '{32'h6, 32'h3, 32'h0};
    logic        we   [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    preload(6'd0, 32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      d_xfer(we[k], sz[k], 1'b0, ad[k], 32'hFFFF_FFFF, lat, rd, err, sw);
      n_total++;
      if (err !== 1'b1 || rd !== 32'h0 || sw !== 1'b0 || lat != 1)
        $display("FAIL err_case%0d: err=%b rdata=%h saw_write=%b lat=%0d, want 1/0/0/1",
                 k, err, rd, sw, lat);
      else n_pass++;
    end
    n_total++;
    if (mem[0] !== 32'h1234_5678)
      $display("FAIL err_mem_untouched: mem0=%h, want 12345678", mem[0]);
    else n_pass++;
  endtask

  task automatic test_reset_in_rmw();
    int          lat;
    logic [31:0] rd;
    logic        err, sw;
    do_reset();
    preload(6'd3, 32'h1122_3344);
    bus.d_we    = 1'b1;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'hC;
    bus.d_wdata = 32'h55;
    bus.d_req   = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    n_total++;
    if (bus.m_write !== 1'b1 || bus.m_addr !== 6'd3 || bus.m_wdata !== 32'h1122_3355)
      $display("FAIL rmw_before_rst: wr=%b addr=%0d wdata=%h, want 1/3/11223355",
               bus.m_write, bus.m_addr, bus.m_wdata);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.m_write !== 1'b0 || bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0)
      $display("FAIL rmw_rst_drop: wr=%b d_ack=%b i_ack=%b, want 0/0/0",
               bus.m_write, bus.d_ack, bus.i_ack);
    else n_pass++;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (mem[3] !== 32'h1122_3344 || bus.d_ack !== 1'b0)
      $display("FAIL rmw_rst_mem: mem3=%h d_ack=%b, want 11223344/0", mem[3], bus.d_ack);
    else n_pass++;
    @(posedge clk);
    #1;
    d_xfer(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, lat, rd, err, sw);
    n_total++;
    if (rd !== 32'h1122_3344 || lat != 1 || err !== 1'b0)
      $display("FAIL post_rst_lw: rdata=%h lat=%0d err=%b, want 11223344/1/0", rd, lat, err);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    for (int a = 0; a < 64; a++) mem[a] = 32'h0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_size = 2'b10; bus.d_unsigned = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_fetch();
    test_round_robin();
    test_loads();
    test_sub_store();
    test_errors();
    test_reset_in_rmw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
